ceespu_execute_mc: RTL and testbench

Parametrised next-generation CEESPU execute stage. It contains a built-in single-cycle ALU, a branch comparator, a load-data aligner, a carry flag and an iterative multiplier with a stall handshake. It sits between decode/operand-fetch and the writeback register file. Its outputs are registered: one instruction per cycle, except multiplies, which stall upstream.

---
 rtl/ceespu_execute_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_ceespu_execute_mc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ceespu_execute_mc.sv
// rtl/ceespu_execute_mc.sv - CEESPU execute stage: ALU, branch compare, load align, carry flag, iterative multiplier
module ceespu_execute_mc #(
    parameter int DW  = 32,
    parameter int PCW = 14,
    parameter int MRB = 1
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic           I_valid,
    input  logic           I_flush,
    input  logic [4:0]     I_selD,
    input  logic           I_we,
    input  logic [3:0]     I_aluop,
    input  logic [1:0]     I_selCin,
    input  logic           I_branch,
    input  logic [2:0]     I_branchop,
    input  logic [1:0]     I_selWb,
    input  logic [DW-1:0]  I_dataA,
    input  logic [DW-1:0]  I_dataB,
    input  logic [DW-1:0]  I_memA,
    input  logic [3:0]     I_selMem,
    input  logic [PCW-1:0] I_PC,
    output logic           O_stall,
    output logic           O_valid,
    output logic [4:0]     O_selD,
    output logic           O_we,
    output logic [DW-1:0]  O_dataD,
    output logic           O_branch
);

    localparam int N  = DW / MRB;
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t          state;
    logic            c_flag;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc_next;
    logic [DW-1:0]   mplier;
    logic            mul_hi;

    logic            is_mul;
    logic            is_addsub;
    logic            cin;
    logic [DW-1:0]   alu_b;
    logic [DW:0]     sum;
    logic [SW-1:0]   shamt;
    logic [DW-1:0]   alu_res;
    logic [DW-1:0]   ld_val;
    logic [DW-1:0]   wb_val;
    logic            cond;
    logic [31:0]     mem_w;
    logic            ld_fill;

    assign is_mul    = (I_aluop == 4'd8) || (I_aluop == 4'd9);
    assign is_addsub = (I_aluop == 4'd0) || (I_aluop == 4'd1);
    assign alu_b     = (I_aluop == 4'd1) ? ~I_dataB : I_dataB;
    assign sum       = {1'b0, I_dataA} + {1'b0, alu_b} + {{DW{1'b0}}, cin};
    assign shamt     = I_dataB[SW-1:0];
    assign mem_w     = I_memA[31:0];

    // Carry-in source selection
    always_comb begin
        cin = 1'b0;
        case (I_selCin)
            2'd0: cin = 1'b0;
            2'd1: cin = c_flag;
            2'd2: cin = ~c_flag;
            2'd3: cin = 1'b1;
            default: cin = 1'b0;
        endcase
    end

    // Single-cycle ALU result; multiply opcodes produce their result through the FSM
    always_comb begin
        alu_res = '0;
        case (I_aluop)
            4'd0, 4'd1: alu_res = sum[DW-1:0];
            4'd2: alu_res = I_dataA & I_dataB;
            4'd3: alu_res = I_dataA | I_dataB;
            4'd4: alu_res = I_dataA ^ I_dataB;
            4'd5: alu_res = I_dataA << shamt;
            4'd6: alu_res = I_dataA >> shamt;
            4'd7: alu_res = $unsigned($signed(I_dataA) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Load aligner: fill with the sign bit first, then overlay the selected lane
    always_comb begin
        ld_fill = 1'b0;
        if (I_selMem[2])
            ld_fill = I_selMem[3] & mem_w[8*I_selMem[1:0] + 7];
        else if (I_selMem[1])
            ld_fill = I_selMem[3] & mem_w[16*I_selMem[0] + 15];
        else
            ld_fill = I_selMem[3] & mem_w[31];
        ld_val = {DW{ld_fill}};
        if (I_selMem[2])
            ld_val[7:0] = mem_w[8*I_selMem[1:0] +: 8];
        else if (I_selMem[1])
            ld_val[15:0] = mem_w[16*I_selMem[0] +: 16];
        else
            ld_val[31:0] = mem_w;
    end

    // Writeback source mux; the link value is PC+1 after zero extension, so it may exceed PCW bits
    always_comb begin
        wb_val = '0;
        case (I_selWb)
            2'd0: wb_val = alu_res;
            2'd1: wb_val = ld_val;
            2'd2: wb_val = {{(DW-PCW){1'b0}}, I_PC} + {{(DW-1){1'b0}}, 1'b1};
            2'd3: wb_val = I_dataB;
            default: wb_val = '0;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        cond = 1'b0;
        case (I_branchop)
            3'd0: cond = (I_dataA == I_dataB);
            3'd1: cond = (I_dataA != I_dataB);
            3'd2: cond = (I_dataA < I_dataB);
            3'd3: cond = (I_dataA >= I_dataB);
            3'd4: cond = ($signed(I_dataA) < $signed(I_dataB));
            3'd5: cond = ($signed(I_dataA) >= $signed(I_dataB));
            3'd6: cond = c_flag;
            3'd7: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // One shift-add step retiring MRB multiplier bits
    always_comb begin
        acc_next = acc;
        for (int j = 0; j < MRB; j++) begin
            if (mplier[j])
                acc_next = acc_next + (mcand << j);
        end
    end

    // Stall covers the launch cycle in IDLE plus every MUL cycle
    assign O_stall  = (state == S_MUL) ||
                      ((state == S_IDLE) && I_valid && is_mul && !I_flush);
    assign O_branch = I_valid & I_branch & cond & ~I_flush & ~O_stall;

    // Stage registers, carry flag and multiply FSM
    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            state   <= S_IDLE;
            c_flag  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_hi  <= 1'b0;
            O_valid <= 1'b0;
            O_we    <= 1'b0;
            O_selD  <= '0;
            O_dataD <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_valid && !I_flush && is_mul) begin
                        mcand   <= {{DW{1'b0}}, I_dataA};
                        mplier  <= I_dataB;
                        acc     <= '0;
                        cnt     <= CW'(N);
                        mul_hi  <= (I_aluop == 4'd9);
                        state   <= S_MUL;
                        O_valid <= 1'b0;
                        O_we    <= 1'b0;
                    end else if (I_valid && !I_flush) begin
                        O_valid <= 1'b1;
                        O_we    <= I_we;
                        O_selD  <= I_selD;
                        O_dataD <= wb_val;
                        if (is_addsub)
                            c_flag <= sum[DW];
                    end else begin
                        O_valid <= 1'b0;
                        O_we    <= 1'b0;
                    end
                end
                S_MUL: begin
                    O_valid <= 1'b0;
                    O_we    <= 1'b0;
                    if (I_flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << MRB;
                        mplier <= mplier >> MRB;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (I_flush) begin
                        O_valid <= 1'b0;
                        O_we    <= 1'b0;
                    end else begin
                        O_valid <= 1'b1;
                        O_we    <= I_we;
                        O_selD  <= I_selD;
                        O_dataD <= mul_hi ? acc[2*DW-1:DW] : acc[DW-1:0];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_execute_mc.sv
// tb/tb_ceespu_execute_mc.sv - self-checking bench for ceespu_execute_mc
module tb_ceespu_execute_mc;

    localparam int DW = 32;
    localparam int N  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        flush;
    logic [4:0]  seld;
    logic        we;
    logic [3:0]  aluop;
    logic [1:0]  selcin;
    logic        branch;
    logic [2:0]  branchop;
    logic [1:0]  selwb;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] mema;
    logic [3:0]  selmem;
    logic [13:0] pc;
    logic        o_stall;
    logic        o_valid;
    logic [4:0]  o_seld;
    logic        o_we;
    logic [31:0] o_datad;
    logic        o_branch;

    int          total = 0;
    int          bad = 0;
    logic        c_model = 1'b0;
    logic [31:0] last_d = '0;
    logic        last_branch;

    ceespu_execute_mc #(.DW(32), .PCW(14), .MRB(1)) dut (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .I_flush(flush),
        .I_selD(seld), .I_we(we), .I_aluop(aluop), .I_selCin(selcin),
        .I_branch(branch), .I_branchop(branchop), .I_selWb(selwb),
        .I_dataA(dataa), .I_dataB(datab), .I_memA(mema), .I_selMem(selmem),
        .I_PC(pc), .O_stall(o_stall), .O_valid(o_valid), .O_selD(o_seld),
        .O_we(o_we), .O_dataD(o_datad), .O_branch(o_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result}; carry only meaningful for add/sub
    function automatic logic [32:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
        longint unsigned s;
        int              sa;
        int unsigned     sh;
        sh = 32'(b[4:0]);
        sa = a;
        case (op)
            4'd0: begin s = 64'(a) + 64'(b) + 64'(ci); return s[32:0]; end
            4'd1: begin s = 64'(a) + (64'hFFFF_FFFF - 64'(b)) + 64'(ci); return s[32:0]; end
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: begin s = 64'(a) * (64'd1 << sh); return {1'b0, s[31:0]}; end
            4'd6: return {1'b0, 32'(64'(a) / (64'd1 << sh))};
            4'd7: return {1'b0, 32'(sa >>> sh)};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] mem, input logic [3:0] sel);
        logic [31:0] v;
        int          w;
        if (sel[2]) begin
            v = (mem >> (8 * int'(sel[1:0]))) & 32'hFF;
            w = 8;
        end else if (sel[1]) begin
            v = (mem >> (16 * int'(sel[0]))) & 32'hFFFF;
            w = 16;
        end else begin
            v = mem;
            w = 32;
        end
        if (sel[3] && w < 32 && v[w-1])
            v = v | (32'hFFFF_FFFF << w);
        return v;
    endfunction

    function automatic logic m_br(input logic [2:0] bop, input logic [31:0] a,
                                  input logic [31:0] b, input logic c);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (bop)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return a < b;
            3'd3: return a >= b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return c;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] csel, input logic [1:0] wb, input logic [3:0] smem,
                           input logic [31:0] mem, input logic [13:0] p, input logic [2:0] bop);
        logic        ci;
        logic [32:0] r;
        logic [31:0] exp;
        logic [4:0]  d;
        logic        w;
        d  = 5'($urandom);
        w  = 1'($urandom);
        ci = (csel == 2'd0) ? 1'b0 : (csel == 2'd1) ? c_model : (csel == 2'd2) ? ~c_model : 1'b1;
        r  = m_alu(op, a, b, ci);
        case (wb)
            2'd0: exp = r[31:0];
            2'd1: exp = m_load(mem, smem);
            2'd2: exp = 32'(p) + 32'd1;
            default: exp = b;
        endcase
        valid = 1'b1; flush = 1'b0; aluop = op; dataa = a; datab = b; selcin = csel;
        selwb = wb; selmem = smem; mema = mem; pc = p; branchop = bop; branch = 1'b1;
        seld = d; we = w;
        #1;
        last_branch = o_branch;
        chk("branch", o_branch, m_br(bop, a, b, c_model));
        chk("no_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        chk("valid", o_valid, 1'b1);
        chk("we", o_we, w);
        chk("seld", o_seld, d);
        chk("datad", o_datad, exp);
        if (op == 4'd0 || op == 4'd1)
            c_model = r[32];
        last_d = exp;
        branch = 1'b0;
    endtask

    task automatic run_mul(input logic hi, input logic [31:0] a, input logic [31:0] b, input int flush_at);
        longint unsigned p;
        logic [31:0]     exp;
        logic [4:0]      d;
        int              n;
        p   = 64'(a) * 64'(b);
        exp = hi ? p[63:32] : p[31:0];
        d   = 5'($urandom);
        valid = 1'b1; flush = 1'b0; aluop = hi ? 4'd9 : 4'd8; dataa = a; datab = b;
        seld = d; we = 1'b1; branch = 1'b0; selwb = 2'($urandom);
        #1;
        n = 0;
        while (o_stall && n < 100) begin
            n++;
            if (n > 1) chk("stall_valid", o_valid, 1'b0);
            if (flush_at != 0 && n == flush_at) flush = 1'b1;
            @(posedge clk); #1;
        end
        if (flush_at != 0) begin
            chk("flush_stall_len", 64'(n), 64'(flush_at));
            chk("flush_stall", o_stall, 1'b0);
            chk("flush_valid", o_valid, 1'b0);
            chk("flush_we", o_we, 1'b0);
            valid = 1'b0; flush = 1'b0;
        end else begin
            chk("stall_len", 64'(n), 64'(N + 1));
            @(posedge clk); #1;
            chk("mul_valid", o_valid, 1'b1);
            chk("mul_seld", o_seld, d);
            chk("mul_data", o_datad, exp);
            last_d = exp;
            valid = 1'b0;
            @(posedge clk); #1;
            chk("mul_one_shot", o_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; valid = 1'b1; flush = 1'b0; seld = 5'd7; we = 1'b1; aluop = 4'd0;
        selcin = 2'd0; branch = 1'b0; branchop = 3'd0; selwb = 2'd0; dataa = 32'd5;
        datab = 32'd3; mema = 32'd0; selmem = 4'd0; pc = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_we", o_we, 1'b0);
        chk("rst_data", o_datad, 32'd0);
        chk("rst_seld", o_seld, 5'd0);
        rst = 1'b1;

        run_alu(4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 4'd0, 32'd0, 14'd0, 3'd6);
        chk("rst_cflag", o_datad, 32'd0);

        run_alu(4'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 4'd0, 32'd0, 14'd0, 3'd7);
        chk("carry_sum", o_datad, 32'd0);
        run_alu(4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 4'd0, 32'd0, 14'd0, 3'd6);
        chk("carry_used", o_datad, 32'd1);

        run_alu(4'd0, 32'd0, 32'd0, 2'd0, 2'd1, 4'b1111, 32'h8081_F0FF, 14'd0, 3'd0);
        chk("ld_sb3", o_datad, 32'hFFFF_FF80);
        run_alu(4'd0, 32'd0, 32'd0, 2'd0, 2'd1, 4'b0111, 32'h8081_F0FF, 14'd0, 3'd0);
        chk("ld_ub3", o_datad, 32'h0000_0080);
        run_alu(4'd0, 32'd0, 32'd0, 2'd0, 2'd1, 4'b1011, 32'h8081_F0FF, 14'd0, 3'd0);
        chk("ld_sh1", o_datad, 32'hFFFF_8081);
        run_alu(4'd0, 32'd0, 32'd0, 2'd0, 2'd1, 4'b0010, 32'h8081_F0FF, 14'd0, 3'd0);
        chk("ld_uh0", o_datad, 32'h0000_F0FF);

        run_alu(4'd2, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 4'd0, 32'd0, 14'd0, 3'd4);
        chk("blt_taken", last_branch, 1'b1);
        run_alu(4'd2, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 4'd0, 32'd0, 14'd0, 3'd2);
        chk("bltu_not", last_branch, 1'b0);
        run_alu(4'd2, 32'd0, 32'd0, 2'd0, 2'd2, 4'd0, 32'd0, 14'h3FFF, 3'd0);
        chk("link_pc", o_datad, 32'h0000_4000);

        run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mulhu_ones", o_datad, 32'hFFFF_FFFE);
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mul_ones", o_datad, 32'h0000_0001);

        run_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        run_alu(4'd0, 32'd100, 32'd23, 2'd0, 2'd0, 4'd0, 32'd0, 14'd0, 3'd0);
        chk("after_flush_add", o_datad, 32'd123);

        for (int i = 0; i < 4; i++)
            run_mul(1'($urandom), $urandom, $urandom, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 || op == 4'd9) op = 4'd1;
            a = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            run_alu(op, a, b, 2'($urandom), 2'($urandom), 4'($urandom), $urandom,
                    14'($urandom), 3'($urandom));
        end

        valid = 1'b0; aluop = 4'd0; dataa = $urandom; datab = $urandom; branch = 1'b1;
        branchop = 3'd7;
        #1;
        chk("bubble_branch", o_branch, 1'b0);
        @(posedge clk); #1;
        chk("bubble_valid", o_valid, 1'b0);
        chk("bubble_we", o_we, 1'b0);
        chk("bubble_hold", o_datad, last_d);
        valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_bubble", o_valid, 1'b0);
        flush = 1'b0; valid = 1'b0; branch = 1'b0;

        run_alu(4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 4'd0, 32'd0, 14'd0, 3'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
